uart_rx_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tick_gen.sv | 46 ++++
 rtl/uart_rx_cfg.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver and its tick generator.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
      return clk_freq / (baud * ovs);
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick generator: one tick every DIV clocks while enabled, plus a
// modulo-OVS index of the current tick. Held cleared while disabled.
module uart_tick_gen #(
   parameter int DIV = 108,
   parameter int OVS = 8,
   localparam int IW = $clog2(OVS),
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          tick,
   output logic [IW-1:0] bit_tick_idx
);

   logic [DW-1:0] div_q, div_d;
   logic [IW-1:0] idx_q, idx_d;

   always_comb begin
      tick  = en && (div_q == DW'(DIV - 1));
      div_d = div_q;
      idx_d = idx_q;
      if (!en) begin
         div_d = '0;
         idx_d = '0;
      end else if (tick) begin
         div_d = '0;
         idx_d = (idx_q == IW'(OVS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
         div_d = div_q + DW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
      end
   end

   assign bit_tick_idx = idx_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable-frame UART receiver: synchroniser, glitch-rejecting start detect,
// 3-sample majority per bit, parity/framing/overrun flags and a one-word holding register.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD      = 115200,
   parameter int OVS       = 8,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 d_in,
   input  logic                 rx_en,
   input  logic                 d_ack,
   output logic [DATA_BITS-1:0] d_out,
   output logic                 d_valid,
   output logic                 busy,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVS);
   localparam int IW  = $clog2(OVS);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_rx_cfg: CLK_FREQ/(BAUD*OVS) must be at least 2");
      end
   endgenerate

   logic sync1_q, sync2_q, rxs_prev_q, rxs;
   state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic samp0_q, samp0_d, samp1_q, samp1_d;
   logic pe_q, pe_d, fe_q, fe_d, done_q, done_d;
   logic complete, maj, decide;
   logic tick;
   logic [IW-1:0] tick_idx, rel;

   logic [DATA_BITS-1:0] d_out_q, d_out_d;
   logic d_valid_q, d_valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

   assign rxs = sync2_q;

   uart_tick_gen #(.DIV(DIV), .OVS(OVS)) u_tick (
      .clk          (clk),
      .rst          (rst),
      .en           (state_q != IDLE),
      .tick         (tick),
      .bit_tick_idx (tick_idx)
   );

   // Re-reference tick indices to the start-bit centre, which falls on tick OVS/2-1.
   always_comb begin
      if (tick_idx >= IW'(OVS / 2 - 1)) rel = tick_idx - IW'(OVS / 2 - 1);
      else                              rel = tick_idx + IW'(OVS / 2 + 1);
   end

   assign maj    = (samp0_q & samp1_q) | (samp0_q & rxs) | (samp1_q & rxs);
   assign decide = tick && (rel == IW'(1));

   always_comb begin
      samp0_d = samp0_q;
      samp1_d = samp1_q;
      if (tick && rel == IW'(OVS - 1)) samp0_d = rxs;
      if (tick && rel == '0)           samp1_d = rxs;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      pe_d     = pe_q;
      fe_d     = fe_q;
      done_d   = done_q;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_en && rxs_prev_q && !rxs) begin
               state_d = START;
               cnt_d   = '0;
               pe_d    = 1'b0;
               fe_d    = 1'b0;
               done_d  = 1'b0;
            end
         end
         START: begin
            if (decide) begin
               if (maj) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  cnt_d   = '0;
               end
            end
         end
         DATA: begin
            if (decide) begin
               shift_d = {maj, shift_q[DATA_BITS-1:1]};
               if (cnt_q == LAST_DATA) begin
                  cnt_d   = '0;
                  state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         uart_pkg::PARITY: begin
            if (decide) begin
               pe_d    = (PARITY == PAR_ODD) ? (maj == ^shift_q) : (maj != ^shift_q);
               cnt_d   = '0;
               state_d = STOP;
            end
         end
         STOP: begin
            if (done_q) begin
               complete = 1'b1;
               done_d   = 1'b0;
               state_d  = IDLE;
            end else if (decide) begin
               if (!maj) fe_d = 1'b1;
               if (cnt_q == LAST_STOP) done_d = 1'b1;
               else                    cnt_d  = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Holding register: a completion always loads; d_ack in the same cycle suppresses overrun.
   always_comb begin
      d_out_d   = d_out_q;
      d_valid_d = d_valid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      ovr_d     = 1'b0;
      if (complete) begin
         d_out_d   = shift_q;
         perr_d    = pe_q;
         ferr_d    = fe_q;
         d_valid_d = 1'b1;
         ovr_d     = d_valid_q & ~d_ack;
      end else if (d_ack && d_valid_q) begin
         d_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rxs_prev_q <= 1'b1;
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         samp0_q    <= 1'b0;
         samp1_q    <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         done_q     <= 1'b0;
         d_out_q    <= '0;
         d_valid_q  <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         sync1_q    <= d_in;
         sync2_q    <= sync1_q;
         rxs_prev_q <= rxs;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         samp0_q    <= samp0_d;
         samp1_q    <= samp1_d;
         pe_q       <= pe_d;
         fe_q       <= fe_d;
         done_q     <= done_d;
         d_out_q    <= d_out_d;
         d_valid_q  <= d_valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign d_out      = d_out_q;
   assign d_valid    = d_valid_q;
   assign busy       = (state_q != IDLE);
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench: a default 8N1 receiver, a fast 8N1 receiver and a fast 7E2 receiver.
module tb_uart_rx_cfg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic line [3];
   logic en   [3];
   logic ack  [3];
   logic dv   [3];
   logic bsy  [3];
   logic pe   [3];
   logic fe   [3];
   logic ovr  [3];
   logic [7:0] dout0, dout1;
   logic [6:0] dout2;

   int checks = 0;
   int errors = 0;
   int vcnt [3];
   int ocnt [3];
   logic vprev [3];

   uart_rx_cfg u_def (
      .clk(clk), .rst(rst), .d_in(line[0]), .rx_en(en[0]), .d_ack(ack[0]),
      .d_out(dout0), .d_valid(dv[0]), .busy(bsy[0]), .parity_err(pe[0]),
      .frame_err(fe[0]), .overrun(ovr[0])
   );

   uart_rx_cfg #(.CLK_FREQ(100000000), .BAUD(1562500), .OVS(8)) u_fast (
      .clk(clk), .rst(rst), .d_in(line[1]), .rx_en(en[1]), .d_ack(ack[1]),
      .d_out(dout1), .d_valid(dv[1]), .busy(bsy[1]), .parity_err(pe[1]),
      .frame_err(fe[1]), .overrun(ovr[1])
   );

   uart_rx_cfg #(.CLK_FREQ(100000000), .BAUD(1562500), .OVS(8),
                 .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_par (
      .clk(clk), .rst(rst), .d_in(line[2]), .rx_en(en[2]), .d_ack(ack[2]),
      .d_out(dout2), .d_valid(dv[2]), .busy(bsy[2]), .parity_err(pe[2]),
      .frame_err(fe[2]), .overrun(ovr[2])
   );

   always @(negedge clk) begin
      for (int u = 0; u < 3; u++) begin
         if (dv[u] && !vprev[u]) vcnt[u] <= vcnt[u] + 1;
         if (ovr[u]) ocnt[u] <= ocnt[u] + 1;
         vprev[u] <= dv[u];
      end
   end

   typedef struct {
      int         u;
      logic [8:0] data;
      logic       par;
      logic       stop;
      logic [8:0] exp_d;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   localparam int NV = 11;
   vec_t vt [NV];

   function automatic logic [8:0] dout_of(input int u);
      case (u)
         0:       return {1'b0, dout0};
         1:       return {1'b0, dout1};
         default: return {2'b00, dout2};
      endcase
   endfunction

   function automatic int bp_of(input int u);
      return (u == 0) ? 864 : 64;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int u, input logic [8:0] data, input logic par,
                             input logic stop_lvl, input int brk_bits);
      int bp, nb, ns;
      bp = bp_of(u);
      nb = (u == 2) ? 7 : 8;
      ns = (u == 2) ? 2 : 1;
      line[u] = 1'b0;
      tick(bp);
      for (int i = 0; i < nb; i++) begin
         line[u] = data[i];
         tick(bp);
      end
      if (u == 2) begin
         line[u] = par;
         tick(bp);
      end
      for (int i = 0; i < ns; i++) begin
         line[u] = stop_lvl;
         tick(bp);
      end
      if (brk_bits > 0) begin
         line[u] = 1'b0;
         tick(brk_bits * bp);
      end
      line[u] = 1'b1;
   endtask

   task automatic wait_valid(input int u, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (dv[u]) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic wait_busy(input int u, input logic lvl, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (bsy[u] == lvl) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic do_ack(input int u, input logic [8:0] exp_d);
      ack[u] = 1'b1;
      tick(1);
      ack[u] = 1'b0;
      chk("ack_clears_valid", dv[u], 0);
      chk("ack_holds_dout", dout_of(u), exp_d);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok, ok1, ok2, ok3;
      int v0, o0;

      vt[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
      vt[1]  = '{1, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
      vt[2]  = '{1, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
      vt[3]  = '{1, 9'h05A, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0};
      vt[4]  = '{1, 9'h080, 1'b0, 1'b1, 9'h080, 1'b0, 1'b0};
      vt[5]  = '{2, 9'h041, 1'b1, 1'b1, 9'h041, 1'b1, 1'b0};
      vt[6]  = '{2, 9'h041, 1'b0, 1'b1, 9'h041, 1'b0, 1'b0};
      vt[7]  = '{2, 9'h043, 1'b1, 1'b1, 9'h043, 1'b0, 1'b0};
      vt[8]  = '{2, 9'h043, 1'b0, 1'b1, 9'h043, 1'b1, 1'b0};
      vt[9]  = '{2, 9'h07F, 1'b1, 1'b1, 9'h07F, 1'b0, 1'b0};
      vt[10] = '{2, 9'h041, 1'b0, 1'b0, 9'h041, 1'b0, 1'b1};

      rst = 1'b1;
      for (int u = 0; u < 3; u++) begin
         line[u] = 1'b1;
         en[u]   = 1'b1;
         ack[u]  = 1'b0;
      end
      tick(3);
      for (int u = 0; u < 3; u++) begin
         chk("reset_valid", dv[u], 0);
         chk("reset_busy", bsy[u], 0);
         chk("reset_dout", dout_of(u), 0);
         chk("reset_flags", {pe[u], fe[u], ovr[u]}, 0);
      end
      rst = 1'b0;
      tick(5);

      for (int k = 0; k < NV; k++) begin
         v0 = vcnt[vt[k].u];
         send_frame(vt[k].u, vt[k].data, vt[k].par, vt[k].stop, 0);
         wait_valid(vt[k].u, 2 * bp_of(vt[k].u), ok);
         chk("vec_valid_timeout", ok, 1);
         chk("vec_valid_events", vcnt[vt[k].u] - v0, 1);
         chk("vec_dout", dout_of(vt[k].u), vt[k].exp_d);
         chk("vec_parity_err", pe[vt[k].u], vt[k].exp_pe);
         chk("vec_frame_err", fe[vt[k].u], vt[k].exp_fe);
         $display("vec %0d unit %0d sent %03h got %03h pe %0d fe %0d", k, vt[k].u,
                  vt[k].data, dout_of(vt[k].u), pe[vt[k].u], fe[vt[k].u]);
         do_ack(vt[k].u, vt[k].exp_d);
         tick(10);
      end

      // Start-bit glitch shorter than half a bit
      v0 = vcnt[0];
      line[0] = 1'b0;
      tick(100);
      chk("glitch_busy_rises", bsy[0], 1);
      tick(100);
      line[0] = 1'b1;
      tick(664);
      chk("glitch_busy_falls", bsy[0], 0);
      chk("glitch_no_valid", vcnt[0] - v0, 0);
      $display("glitch test done");

      // Stop bit low followed by a 20-bit break
      v0 = vcnt[1];
      o0 = ocnt[1];
      send_frame(1, 9'h03C, 1'b0, 1'b0, 20);
      tick(5);
      chk("break_one_valid", vcnt[1] - v0, 1);
      chk("break_dout", dout_of(1), 9'h03C);
      chk("break_frame_err", fe[1], 1);
      chk("break_no_overrun", ocnt[1] - o0, 0);
      chk("break_idle", bsy[1], 0);
      $display("break test dout %02h fe %0d", dout1, fe[1]);
      do_ack(1, 9'h03C);

      // rx_en low in IDLE ignores frames; falling mid-frame does not abort
      en[1] = 1'b0;
      v0 = vcnt[1];
      send_frame(1, 9'h055, 1'b0, 1'b1, 0);
      tick(64);
      chk("rxen_low_no_valid", vcnt[1] - v0, 0);
      en[1] = 1'b1;
      fork
         send_frame(1, 9'h096, 1'b0, 1'b1, 0);
         begin
            tick(300);
            en[1] = 1'b0;
         end
      join
      wait_valid(1, 128, ok);
      chk("rxen_fall_completes", ok, 1);
      chk("rxen_fall_dout", dout_of(1), 9'h096);
      $display("rx_en test dout %02h", dout1);
      en[1] = 1'b1;
      do_ack(1, 9'h096);
      tick(10);

      // Back-to-back without acknowledge: one overrun, newest word kept
      o0 = ocnt[1];
      send_frame(1, 9'h011, 1'b0, 1'b1, 0);
      send_frame(1, 9'h022, 1'b0, 1'b1, 0);
      wait_valid(1, 128, ok);
      tick(2);
      chk("overrun_once", ocnt[1] - o0, 1);
      chk("overrun_dout", dout_of(1), 9'h022);
      chk("overrun_valid", dv[1], 1);
      $display("overrun test dout %02h overruns %0d", dout1, ocnt[1] - o0);
      do_ack(1, 9'h022);
      tick(10);

      // Acknowledge coincident with the second completion: no overrun
      o0 = ocnt[1];
      fork
         begin
            send_frame(1, 9'h011, 1'b0, 1'b1, 0);
            send_frame(1, 9'h022, 1'b0, 1'b1, 0);
         end
         begin
            wait_busy(1, 1'b1, 200, ok1);
            wait_busy(1, 1'b0, 800, ok2);
            wait_busy(1, 1'b1, 200, ok3);
            tick(616);
            ack[1] = 1'b1;
            tick(1);
            ack[1] = 1'b0;
         end
      join
      tick(2);
      chk("coinc_busy_seen", {ok1, ok2, ok3}, 3'b111);
      chk("coinc_no_overrun", ocnt[1] - o0, 0);
      chk("coinc_valid_kept", dv[1], 1);
      chk("coinc_dout", dout_of(1), 9'h022);
      $display("coincident ack test dout %02h overruns %0d", dout1, ocnt[1] - o0);

      // Asynchronous reset in the middle of bit 4 of 0xF0
      v0 = vcnt[0];
      fork
         send_frame(0, 9'h0F0, 1'b0, 1'b1, 0);
         begin
            tick(864 * 5 + 432);
            chk("rst_busy_before", bsy[0], 1);
            #2 rst = 1'b1;
            #1;
            chk("rst_busy_async", bsy[0], 0);
            chk("rst_valid_async", dv[1], 0);
            chk("rst_dout_async", dout_of(1), 0);
            tick(3);
            rst = 1'b0;
         end
      join
      tick(10);
      chk("rst_abort_no_valid", vcnt[0] - v0, 0);
      send_frame(0, 9'h00F, 1'b0, 1'b1, 0);
      wait_valid(0, 2 * 864, ok);
      chk("after_rst_valid", ok, 1);
      chk("after_rst_dout", dout_of(0), 9'h00F);
      chk("after_rst_flags", {pe[0], fe[0]}, 0);
      $display("reset test dout %02h", dout0);
      do_ack(0, 9'h00F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
